// File: rtl/ti_audio_pkg.sv
// rtl/ti_audio_pkg.sv - shared constants, state type and sample conversion for the I2S transmit path
//
// Purpose: common definitions imported by ti_i2s_tx and ti_i2s_clkgen.
//   SLOT_BITS   : bits per I2S channel slot word
//   FRAME_SLOTS : bclk slots per stereo frame
//   SLOT_W      : width of the slot counter
//   MIDSCALE    : offset that recentres the unsigned mixer range around zero
//   i2s_state_t : transmitter FSM states
//   to_word()   : unsigned mixer sample -> 16-bit two's complement word
package ti_audio_pkg;

  localparam int SLOT_BITS   = 16;
  localparam int FRAME_SLOTS = 32;
  localparam int SLOT_W      = $clog2(FRAME_SLOTS);

  localparam logic [SLOT_BITS-1:0] MIDSCALE = 16'h4000;

  typedef enum logic {IDLE, RUN} i2s_state_t;

  // 0..32767 maps to 0xC000..0x3FFF; the subtraction wraps in 16 bits on purpose.
  function automatic logic [SLOT_BITS-1:0] to_word(input logic [SLOT_BITS-2:0] s);
    return {1'b0, s} - MIDSCALE;
  endfunction

endpackage

// File: rtl/ti_i2s_clkgen.sv
// rtl/ti_i2s_clkgen.sv - bit clock, slot strobe and slot counter for the I2S transmitter
//
// Purpose: divides CLK into bclk slots of 2*CLK_DIV cycles and counts slots in a frame.
// Ports:
//   CLK        in   system clock
//   RST        in   synchronous reset, active-high
//   run        in   transmitter is running; when low the counters are held cleared
//   start      in   the coming edge starts the very first slot (leaving IDLE)
//   bclk       out  bit clock: low for the first CLK_DIV cycles of a slot, high for the rest
//   slot_start out  the coming edge begins a new slot (bclk falling edge)
//   slot_cnt   out  index of the current slot, 0..FRAME_SLOTS-1
module ti_i2s_clkgen
  import ti_audio_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              run,
  input  logic              start,
  output logic              bclk,
  output logic              slot_start,
  output logic [SLOT_W-1:0] slot_cnt
);

  localparam int PH_W = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_HIGH = PH_W'(CLK_DIV);

  logic [PH_W-1:0] ph;

  always_ff @(posedge CLK) begin
    if (RST || !run) begin
      ph       <= '0;
      slot_cnt <= '0;
    end else if (ph == PH_LAST) begin
      ph       <= '0;
      slot_cnt <= slot_cnt + SLOT_W'(1);
    end else begin
      ph <= ph + PH_W'(1);
    end
  end

  // Phase is held at 0 while idle, so bclk rests low without a separate gate.
  assign bclk       = (ph >= PH_HIGH);
  assign slot_start = start | (run & (ph == PH_LAST));

endmodule

// File: rtl/ti_i2s_tx.sv
// rtl/ti_i2s_tx.sv - I2S transmitter: mono-duplicated 16-bit frames from 15-bit unsigned samples
//
// Purpose: holds one sample, converts it to two's complement and serializes it MSB first
// on both I2S channels with the standard one-bit delay after word select.
// Ports:
//   CLK          in   system clock
//   RST          in   synchronous reset, active-high
//   sample_in    in   unsigned mixer sample, 0..32767
//   sample_valid in   sample_in is valid this cycle
//   sample_ready out  holding register empty; accept on sample_valid & sample_ready
//   bclk         out  I2S bit clock, period 2*CLK_DIV cycles
//   lrclk        out  I2S word select, 0 = left, 1 = right
//   sdata        out  I2S serial data, MSB first
//   underrun     out  one-cycle pulse when a frame starts without a new sample
module ti_i2s_tx
  import ti_audio_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [SLOT_BITS-2:0] sample_in,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  output logic                 bclk,
  output logic                 lrclk,
  output logic                 sdata,
  output logic                 underrun
);

  i2s_state_t state, state_nxt;

  logic                 full;
  logic [SLOT_BITS-1:0] hold_word;
  logic [SLOT_BITS-1:0] cur_word;
  logic [SLOT_BITS-1:0] shreg;
  logic                 accept;
  logic                 start;
  logic                 slot_start;
  logic [SLOT_W-1:0]    slot_cnt;
  logic [SLOT_W-1:0]    slot_nxt;

  assign sample_ready = ~full;
  assign accept       = sample_valid & ~full;

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (full) begin
          state_nxt = RUN;
          start     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  ti_i2s_clkgen #(
    .CLK_DIV(CLK_DIV)
  ) u_clkgen (
    .CLK       (CLK),
    .RST       (RST),
    .run       (state == RUN),
    .start     (start),
    .bclk      (bclk),
    .slot_start(slot_start),
    .slot_cnt  (slot_cnt)
  );

  // Slot that begins at the coming slot_start edge; leaving IDLE always begins slot 0.
  assign slot_nxt = (state == RUN) ? slot_cnt + SLOT_W'(1) : '0;

  // shreg rotates left once per emitted bit. After slots 1..16 it is back to the
  // loaded word, and after slots 17..31 it has rotated by 31, leaving bit0 on top
  // for the delayed LSB in the next frame's slot 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      full      <= 1'b0;
      hold_word <= '0;
      cur_word  <= '0;
      shreg     <= '0;
      lrclk     <= 1'b0;
      sdata     <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state    <= state_nxt;
      underrun <= 1'b0;

      if (accept) begin
        full      <= 1'b1;
        hold_word <= to_word(sample_in);
      end

      if (slot_start) begin
        lrclk <= slot_nxt[SLOT_W-1];
        if (slot_nxt == '0) begin
          // The first frame after IDLE has no previous word to finish.
          sdata <= (state == RUN) ? shreg[SLOT_BITS-1] : 1'b0;
          if (full) begin
            shreg    <= hold_word;
            cur_word <= hold_word;
            full     <= 1'b0;
          end else begin
            shreg    <= cur_word;
            underrun <= 1'b1;
          end
        end else begin
          sdata <= shreg[SLOT_BITS-1];
          shreg <= {shreg[SLOT_BITS-2:0], shreg[SLOT_BITS-1]};
        end
      end
    end
  end

endmodule

// File: tb/tb_ti_i2s_tx.sv
// tb/tb_ti_i2s_tx.sv - randomized self-checking bench for ti_i2s_tx at CLK_DIV 4 and 1
module tb_ti_i2s_tx;

  localparam int CD0 = 4;
  localparam int CD1 = 1;

  int cd [2] = '{CD0, CD1};

  logic        clk;
  logic [1:0]  rst;
  logic [1:0]  valid;
  logic [14:0] din [2];
  logic [1:0]  s_ready, s_bclk, s_lrclk, s_sdata, s_underrun;

  ti_i2s_tx #(.CLK_DIV(CD0)) dut0 (
    .CLK(clk), .RST(rst[0]), .sample_in(din[0]), .sample_valid(valid[0]),
    .sample_ready(s_ready[0]), .bclk(s_bclk[0]), .lrclk(s_lrclk[0]),
    .sdata(s_sdata[0]), .underrun(s_underrun[0])
  );

  ti_i2s_tx #(.CLK_DIV(CD1)) dut1 (
    .CLK(clk), .RST(rst[1]), .sample_in(din[1]), .sample_valid(valid[1]),
    .sample_ready(s_ready[1]), .bclk(s_bclk[1]), .lrclk(s_lrclk[1]),
    .sdata(s_sdata[1]), .underrun(s_underrun[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cycle, got, exp);
    end
  endtask

  // Reference model: time since the first slot 0, frame/slot/phase by division.
  bit          m_run  [2];
  int          m_k    [2];
  bit          m_full [2];
  bit          m_und  [2];
  bit          m_acc  [2];
  logic [15:0] m_hold [2];
  logic [15:0] m_cur  [2];
  logic [15:0] m_prev [2];

  // Sample source per instance.
  logic [14:0] lst   [2][16];
  int          n_lst [2];
  int          idx   [2];
  bit          gap   [2];

  function automatic logic [15:0] conv(input logic [14:0] s);
    int v;
    v = int'(s) - 16384;
    return 16'(v);
  endfunction

  task automatic model_step(input int i);
    bit acc, load;
    acc      = valid[i] && !m_full[i];
    m_acc[i] = 1'b0;
    m_und[i] = 1'b0;
    if (rst[i]) begin
      m_run[i] = 0; m_k[i] = 0; m_full[i] = 0;
      m_hold[i] = '0; m_cur[i] = '0; m_prev[i] = '0;
    end else begin
      m_acc[i] = acc;
      load = 1'b0;
      if (!m_run[i]) begin
        if (m_full[i]) begin
          m_run[i] = 1; m_k[i] = 0; load = 1'b1;
        end
      end else begin
        m_k[i]++;
        if (m_k[i] % (64 * cd[i]) == 0) load = 1'b1;
      end
      if (load) begin
        m_prev[i] = m_cur[i];
        if (m_full[i]) begin
          m_cur[i]  = m_hold[i];
          m_full[i] = 0;
        end else begin
          m_und[i] = 1'b1;
        end
      end
      if (acc) begin
        m_full[i] = 1;
        m_hold[i] = conv(din[i]);
      end
    end
  endtask

  task automatic compare(input int i);
    int ph, slot, frame;
    logic eb, el, es;
    eb = 0; el = 0; es = 0;
    if (m_run[i]) begin
      ph    = m_k[i] % (2 * cd[i]);
      slot  = (m_k[i] / (2 * cd[i])) % 32;
      frame = m_k[i] / (64 * cd[i]);
      eb    = (ph >= cd[i]);
      el    = (slot >= 16);
      if (slot == 0)       es = (frame == 0) ? 1'b0 : m_prev[i][0];
      else if (slot <= 16) es = m_cur[i][16 - slot];
      else                 es = m_cur[i][32 - slot];
    end
    check_eq($sformatf("ready%0d", i),    32'(s_ready[i]),    32'(!m_full[i]));
    check_eq($sformatf("bclk%0d", i),     32'(s_bclk[i]),     32'(eb));
    check_eq($sformatf("lrclk%0d", i),    32'(s_lrclk[i]),    32'(el));
    check_eq($sformatf("sdata%0d", i),    32'(s_sdata[i]),    32'(es));
    check_eq($sformatf("underrun%0d", i), 32'(s_underrun[i]), 32'(m_und[i]));
  endtask

  // Holds data steady while valid and not yet accepted.
  task automatic produce(input int i);
    if (valid[i] && m_acc[i]) idx[i]++;
    if (!(valid[i] && !m_acc[i])) begin
      if (idx[i] < n_lst[i] && (!gap[i] || $urandom_range(0, 3) == 0)) begin
        valid[i] = 1'b1;
        din[i]   = lst[i][idx[i]];
      end else begin
        valid[i] = 1'b0;
        din[i]   = 15'($urandom);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cycle++;
    for (int i = 0; i < 2; i++) model_step(i);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      compare(i);
      produce(i);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 2'b11;
    for (int i = 0; i < 2; i++) begin
      n_lst[i] = 0; idx[i] = 0; gap[i] = 0;
    end
    repeat (n) tick();
    rst = 2'b00;
  endtask

  task automatic start_src(input bit g);
    for (int i = 0; i < 2; i++) begin
      idx[i] = 0;
      gap[i] = g;
      produce(i);
    end
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < 2; i++) begin
      n_lst[i] = n;
      for (int j = 0; j < n; j++) lst[i][j] = 15'($urandom);
    end
  endtask

  initial begin
    int waited;
    bit found;
    rst   = 2'b11;
    valid = 2'b00;
    din[0] = '0;
    din[1] = '0;

    // Reset held for 3 cycles, then idle: bclk must stay low, ready high.
    do_reset(3);
    repeat (20) tick();

    // Single full-scale sample, then underruns on every later frame.
    for (int i = 0; i < 2; i++) begin
      n_lst[i] = 1; lst[i][0] = 15'h7FFF;
    end
    start_src(0);
    repeat (3 * 64 * CD0 + 20) tick();

    // Minimum then midscale on consecutive frames: 0xC000 then 0x0000.
    do_reset(2);
    for (int i = 0; i < 2; i++) begin
      n_lst[i] = 2; lst[i][0] = 15'h0000; lst[i][1] = 15'h4000;
    end
    start_src(0);
    repeat (3 * 64 * CD0) tick();

    // Continuous valid: one accept per frame, nothing lost.
    do_reset(2);
    fill_random(12);
    start_src(0);
    repeat (14 * 64 * CD0) tick();

    // Sparse valid with random gaps.
    do_reset(2);
    fill_random(8);
    start_src(1);
    repeat (10 * 64 * CD0) tick();

    // Reset pulse at the start of slot 20 on the CLK_DIV=4 instance.
    do_reset(2);
    fill_random(6);
    start_src(0);
    found  = 0;
    waited = 0;
    while (!found && waited < 2000) begin
      tick();
      waited++;
      if (m_run[0] && (m_k[0] / (2 * CD0)) % 32 == 20 && m_k[0] % (2 * CD0) == 0) found = 1;
    end
    check_eq("slot20_reached", 32'(found), 32'd1);
    rst = 2'b11;
    tick();
    rst = 2'b00;
    repeat (5) tick();
    for (int i = 0; i < 2; i++) idx[i] = 0;
    repeat (2 * 64 * CD0) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
